pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised successor to the fixed-field inter-stage pipeline registers: a single pipeline stage register carrying an opaque DATA_W-bit payload plus a TNEW_W-bit Tnew field. It has a valid/ready handshake and a two-entry skid buffer, so the producer stage is back-pressured without a combinational ready path from downstream. It also provides flush-to-bubble and optional saturating Tnew decrement on capture. It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the WE-gated stall with explicit handshakes.

## Interface
- DATA_W, 32: payload width in bits (instr, PC, operands, control packed by the instantiating stage).
- TNEW_W, 3: Tnew field width.
- TNEW_DEC, 1: 1 = decrement Tnew (saturating at 0) when the entry is captured; 0 = pass Tnew unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries; the stage becomes a bubble next cycle.
- in_valid  in  1  producer offers an entry.
- in_ready  out  1  stage can accept an entry; driven only from registered state.
- in_data  in  DATA_W  payload.
- in_tnew  in  TNEW_W  Tnew of the offered entry.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_data  out  DATA_W  head payload; 0 when empty.
- out_tnew  out  TNEW_W  head Tnew; 0 when empty.
- occupancy  out  2  number of held entries: 0, 1 or 2.
- stall_cnt  out  32  cycles with out_valid=1 and out_ready=0 (see Configuration).
- bubble_cnt  out  32  cycles with out_valid=0 (see Configuration).

## Operation
- Storage: a main entry (drives out_*) and a skid entry, each with valid, data and tnew.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !skid_valid; out_valid = main_valid.
- Captured tnew = TNEW_DEC ? (in_tnew==0 ? 0 : in_tnew-1) : in_tnew.
- States (occupancy):
  - EMPTY:
    - push -> ONE, main <= input.
  - ONE:
    - push & !pop -> TWO, skid <= input.
    - pop & !push -> EMPTY, main cleared.
    - push & pop -> ONE, main <= input.
    - otherwise hold.
  - TWO (in_ready=0, no push possible):
    - pop -> ONE, main <= skid, skid cleared.
    - otherwise hold.
- Cleared means valid=0, data=0, tnew=0, so an empty stage always presents an all-zero bubble (nop).
- flush=1 overrides all transitions: next state EMPTY, both entries cleared. Any push or pop offered in the same cycle is discarded and not counted as a transfer.
- Order is strictly FIFO: the skid entry never overtakes main.
- Tnew is decremented only at capture; a held entry's tnew is not altered and is not decremented again when it moves skid -> main.

## Timing
- Reset (reset=0 at a rising edge): both entries cleared.
  - Outputs next cycle: out_valid=0, out_data=0, out_tnew=0, occupancy=0, in_ready=1, stall_cnt=0, bubble_cnt=0.
- Reset has priority over flush and handshakes. Reset mid-transfer loses all entries.
- Latency: entry pushed at edge N appears on out_* after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready drops the cycle after the skid fills. It rises the cycle after a pop in TWO.
- in_ready has no combinational dependence on out_ready; out_valid has none on in_valid.
- Counters increment at the edge ending the qualifying cycle. They wrap modulo 2^32 and are cleared only by reset, not by flush.

## Configuration
- PIPE_STAGE_BUF_STATS_EN defined: stall_cnt and bubble_cnt implemented as specified.
- Not defined: counter logic is removed; stall_cnt and bubble_cnt are tied to 0; all other behaviour is identical.

## Test plan
- Reset then single push: reset=0 one cycle, release; in_valid=1, in_data=0x00400000, in_tnew=2, TNEW_DEC=1, out_ready=1 -> next cycle out_valid=1, out_data=0x00400000, out_tnew=1, occupancy=1; with TNEW_DEC=0 out_tnew=2; in_tnew=0 with TNEW_DEC=1 -> out_tnew=0.
- Back-pressure: out_ready=0, push A then B -> occupancy=2, in_ready=0, out_data=A; raise out_ready -> A, then B on consecutive cycles, in_ready=1 one cycle after A pops; no entry lost or duplicated.
- Streaming: 16 consecutive pushes 0..15 with out_ready=1 -> outputs 0..15 on 16 consecutive cycles, occupancy stays 1, in_ready stays 1.
- Flush: occupancy=2 with in_valid=1 and flush=1 -> next cycle out_valid=0, out_data=0, out_tnew=0, occupancy=0, in_ready=1; flushed input never appears.
- Reset mid-operation: occupancy=2, reset=0 with flush=0 and push offered -> all outputs at reset values next cycle.
- Stats (macro defined): 3 cycles empty, then 4 cycles valid with out_ready=0, then pop -> bubble_cnt=3, stall_cnt=4; flush leaves both unchanged; macro undefined -> both read 0 throughout.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Purpose: one pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer (main + skid). It carries an opaque DATA_W-bit payload
// and a TNEW_W-bit Tnew field. Tnew is optionally decremented, saturating at 0,
// when an entry is captured. flush turns the stage into a bubble. in_ready
// comes only from registered state, so there is no combinational path from
// out_ready to in_ready.
//
// Optional feature macro: PIPE_STAGE_BUF_STATS_EN
//   defined     -> stall_cnt / bubble_cnt are live cycle counters
//   not defined -> both counters are tied to 0
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   flush      in   discard all held entries
//   in_valid   in   producer offers an entry
//   in_ready   out  stage can accept an entry (registered)
//   in_data    in   DATA_W payload
//   in_tnew    in   TNEW_W Tnew of offered entry
//   out_valid  out  head entry valid
//   out_ready  in   consumer takes head entry
//   out_data   out  head payload (0 when empty)
//   out_tnew   out  head Tnew (0 when empty)
//   occupancy  out  held entries: 0, 1 or 2
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0
//   bubble_cnt out  cycles with out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int DATA_W   = 32,
  parameter int TNEW_W   = 3,
  parameter int TNEW_DEC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);

  // The state encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [TNEW_W-1:0]   main_tnew_q, main_tnew_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [TNEW_W-1:0]   skid_tnew_q, skid_tnew_d;

  logic                main_valid_s;
  logic                ready_s;
  logic                push_s;
  logic                pop_s;
  logic [TNEW_W-1:0]   cap_tnew_s;

  // Tnew as stored at capture: either a saturating decrement or a plain copy.
  function automatic logic [TNEW_W-1:0] capture_tnew(input logic [TNEW_W-1:0] t);
    logic [TNEW_W-1:0] r;
    if (TNEW_DEC != 0) begin
      if (t == {TNEW_W{1'b0}}) begin
        r = {TNEW_W{1'b0}};
      end else begin
        r = t - TNEW_W'(1);
      end
    end else begin
      r = t;
    end
    return r;
  endfunction

  assign main_valid_s = (state_q != ST_EMPTY);
  assign ready_s      = (state_q != ST_TWO);
  assign push_s       = in_valid & ready_s;
  assign pop_s        = main_valid_s & out_ready;
  assign cap_tnew_s   = capture_tnew(in_tnew);

  assign in_ready  = ready_s;
  assign out_valid = main_valid_s;
  assign out_data  = main_data_q;
  assign out_tnew  = main_tnew_q;
  assign occupancy = state_q;

  // Next-state and next-entry logic; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_tnew_d = main_tnew_q;
    skid_data_d = skid_data_q;
    skid_tnew_d = skid_tnew_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = {DATA_W{1'b0}};
      main_tnew_d = {TNEW_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
      skid_tnew_d = {TNEW_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_tnew_d = cap_tnew_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && !pop_s) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_tnew_d = cap_tnew_s;
          end else if (pop_s && !push_s) begin
            state_d     = ST_EMPTY;
            main_data_d = {DATA_W{1'b0}};
            main_tnew_d = {TNEW_W{1'b0}};
          end else if (push_s && pop_s) begin
            main_data_d = in_data;
            main_tnew_d = cap_tnew_s;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // Skid moves to main unchanged; its Tnew was already adjusted at capture.
          if (pop_s) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_tnew_d = skid_tnew_q;
            skid_data_d = {DATA_W{1'b0}};
            skid_tnew_d = {TNEW_W{1'b0}};
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = {DATA_W{1'b0}};
          main_tnew_d = {TNEW_W{1'b0}};
          skid_data_d = {DATA_W{1'b0}};
          skid_tnew_d = {TNEW_W{1'b0}};
        end
      endcase
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= {DATA_W{1'b0}};
      main_tnew_q <= {TNEW_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_tnew_q <= {TNEW_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_tnew_q <= main_tnew_d;
      skid_data_q <= skid_data_d;
      skid_tnew_q <= skid_tnew_d;
    end
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Stall/bubble counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (main_valid_s && !out_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (!main_valid_s) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

endmodule
